rr_stream_mux: RTL
==================

# rr_stream_mux

Parametrised N-channel, W-bit stream multiplexer: the registered, handshaked successor to the combinational 4:1 mux. Multiple producers each present valid/data. A round-robin arbiter picks one channel per cycle, and the chosen beat is captured into a single output register for one downstream consumer. It sits wherever several narrow streams share one sink, such as debug/trace merging or shared-bus front ends.

## Interface
Parameters:
- NCH, 4, number of input channels (≥2)
- DW, 8, data width per channel (≥1)
- CW, $clog2(NCH), channel-index width (derived, not overridden)

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  NCH  per-channel beat valid
- in_ready  output  NCH  per-channel accept, at most one bit high
- in_data  input  NCH*DW  channel i occupies bits [i*DW +: DW]
- in_last  input  NCH  per-channel end-of-packet marker
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts beat
- out_data  output  DW  registered data
- out_chan  output  CW  source channel of the current beat
- out_last  output  1  registered copy of the accepted in_last

## Operation
- load_en = !out_valid || out_ready. The output register accepts a new beat only when load_en is high.
- Arbiter scans channels ptr, ptr+1, …, NCH-1, 0, …, ptr-1 and grants the first with in_valid high.
- in_ready[g] = load_en && grant[g]. It is combinational, one-hot or zero, and forced to 0 while rst_n is low.
- Transfer on channel g (in_valid[g] && in_ready[g]) does the following at the clock edge:
  - out_data ← in_data[g], out_chan ← g, out_last ← in_last[g], out_valid ← 1.
  - ptr ← g+1, wrapping to 0 when g = NCH-1.
- If there is no request and out_ready is high, out_valid ← 0. Data, chan and last hold their values.
- While out_valid && !out_ready, all out_* signals are held stable and all in_ready bits are 0.
- in_valid for a channel that is not granted has no effect. Its data is neither consumed nor dropped.

## Timing
- Reset values: out_valid=0, out_data=0, out_chan=0, out_last=0, ptr=0, state=IDLE.
- Latency: 1 cycle from input transfer to out_valid high.
- Throughput: 1 beat per cycle when out_ready is held high.
- Simultaneous pop and push (out_valid && out_ready && a valid request): the new beat replaces the old one in the same edge, with no bubble.
- Fairness: with all channels continuously valid, grants rotate 0,1,…,NCH-1,0. No channel waits more than NCH-1 transfers.
- Reset asserted mid-operation: the held beat is discarded, out_valid=0 on the next edge, and ptr returns to 0.

## Configuration
- Macro: RR_STREAM_MUX_PKT_LOCK_EN.
- Defined: two-state FSM, IDLE and LOCKED(ch).
  - IDLE → LOCKED(g) on a transfer from g with in_last[g]=0.
  - In LOCKED, only channel ch is eligible. If in_valid[ch] is low, the mux stalls and does not switch channels.
  - LOCKED → IDLE on a transfer from ch with in_last[ch]=1. ptr advances only on that transfer.
  - Packets from different channels are never interleaved.
- Undefined: no FSM. The mux re-arbitrates every beat. in_last is only passed through to out_last.

## Structure
- Package rr_stream_mux_pkg contains:
  - the FSM state enum (IDLE, LOCKED)
  - default NCH/DW localparams
  - a function computing CW
- Sub-module rr_arbiter (NCH): inputs req, ptr and lock/lock_ch; output is the one-hot grant. It is purely combinational.
- The top level holds the output register, ptr, the FSM and the data select.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with all in_valid=1. Expect in_ready=0, out_valid=0, out_data=0, out_chan=0. After release, the first grant goes to channel 0.
- Round-robin: NCH=4, DW=8, all valid, data[i]=8'hA0+i, out_ready=1. Expect out_chan sequence 0,1,2,3,0 on consecutive cycles and out_data A0,A1,A2,A3,A0.
- Backpressure: a beat is held, then out_ready=0 for 5 cycles. Expect out_data/out_chan stable and in_ready=0. When out_ready returns to 1, expect the next grant in the same cycle with no bubble.
- Wrap and sparse: ptr=3 with only channels 1 and 3 valid. Expect grant to 3, then to 1 (ptr wraps to 0 and skips channel 0).
- Lock (macro defined): channel 2 sends 3 beats with last=0,0,1 while channel 0 stays valid, and channel 2 drops valid for 2 cycles mid-packet. Expect a stall and no channel-0 grant until channel 2's last beat, then channel 0 is granted next.
- No lock (macro undefined): same stimulus as the lock scenario. Expect beats from channels 2 and 0 interleaved, with out_last matching each beat.

Source files
------------

// File: rtl/rr_stream_mux_pkg.sv
// Shared types and helpers for the round-robin stream multiplexer.
// Holds the packet-lock FSM state encoding, default geometry and the
// channel-index width function used by the interface, arbiter and top.
package rr_stream_mux_pkg;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } mux_state_e;

    localparam int DEF_NCH = 4;
    localparam int DEF_DW  = 8;

    // Bits needed to index nch channels (nch >= 2), minimum 1.
    function automatic int chan_width(input int nch);
        int w;
        w = 32'sd1;
        while ((32'sd1 << w) < nch) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Handshake bundle between NCH producers, the mux and one consumer.
// master: the side driving producer beats and consumer ready.
// slave:  the mux itself.
interface rr_stream_mux_if
    import rr_stream_mux_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int DW  = DEF_DW
);
    localparam int CW = chan_width(NCH);

    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_chan;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_chan, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_chan, out_last
    );

endinterface

// File: rtl/rr_stream_mux_arbiter.sv
// Combinational round-robin arbiter. Scans from ptr upwards with wrap and
// grants the first requester. When lock is high only lock_ch may win, and
// no grant is issued if that channel is not requesting.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = chan_width(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CW-1:0]  ptr,
    input  logic           lock,
    input  logic [CW-1:0]  lock_ch,
    output logic [NCH-1:0] grant
);

    // Pick the first requesting channel at or after ptr, or the locked one.
    always_comb begin
        logic [CW-1:0] idx_v;
        logic          found_v;
        grant   = '0;
        idx_v   = '0;
        found_v = 1'b0;
        if (lock) begin
            if (req[lock_ch]) begin
                grant[lock_ch] = 1'b1;
            end else begin
                grant = '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                idx_v = CW'((int'(ptr) + i) % NCH);
                if (!found_v && req[idx_v]) begin
                    grant[idx_v] = 1'b1;
                    found_v      = 1'b1;
                end else begin
                    found_v = found_v;
                end
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// Registered round-robin N:1 stream multiplexer with valid/ready handshake.
// One output register is reloaded whenever it is empty or being drained, so
// back-to-back beats flow at one per cycle with no bubble.
// Optional feature macro: RR_STREAM_MUX_PKT_LOCK_EN -- when defined, a
// granted channel keeps the output until it delivers a beat with in_last=1,
// so packets from different channels never interleave.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int DW  = DEF_DW
) (
    input logic          clk,
    input logic          rst_n,
    rr_stream_mux_if.slave bus
);
    localparam int CW = chan_width(NCH);

    logic [CW-1:0]  ptr_r;
    logic           out_valid_r;
    logic [DW-1:0]  out_data_r;
    logic [CW-1:0]  out_chan_r;
    logic           out_last_r;

    logic           load_en_s;
    logic [NCH-1:0] grant_s;
    logic [NCH-1:0] in_ready_s;
    logic           xfer_s;
    logic [CW-1:0]  sel_chan_s;
    logic [DW-1:0]  sel_data_s;
    logic           sel_last_s;
    logic           ptr_adv_s;
    logic [CW-1:0]  ptr_next_s;
    logic           lock_s;
    logic [CW-1:0]  lock_ch_s;

    assign load_en_s = !out_valid_r || bus.out_ready;

    rr_arbiter #(
        .NCH (NCH),
        .CW  (CW)
    ) u_arb (
        .req     (bus.in_valid),
        .ptr     (ptr_r),
        .lock    (lock_s),
        .lock_ch (lock_ch_s),
        .grant   (grant_s)
    );

    // Offer the grant to producers only when the output register can load.
    always_comb begin
        if (rst_n && load_en_s) begin
            in_ready_s = grant_s;
        end else begin
            in_ready_s = '0;
        end
    end

    assign xfer_s = |(bus.in_valid & in_ready_s);

    // Encode the granted channel and select its data and last flag.
    always_comb begin
        sel_chan_s = '0;
        sel_data_s = '0;
        sel_last_s = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_s[i]) begin
                sel_chan_s = CW'(i);
                sel_data_s = bus.in_data[i*DW +: DW];
                sel_last_s = bus.in_last[i];
            end else begin
                sel_chan_s = sel_chan_s;
            end
        end
    end

    // Next scan start is the channel just after the winner, wrapping at NCH.
    always_comb begin
        if (sel_chan_s == CW'(NCH - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = sel_chan_s + CW'(1);
        end
    end

`ifdef RR_STREAM_MUX_PKT_LOCK_EN
    mux_state_e    state_r;
    mux_state_e    state_next_s;
    logic [CW-1:0] lock_ch_r;
    logic [CW-1:0] lock_ch_next_s;

    // Packet-lock state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            lock_ch_r <= '0;
        end else begin
            state_r   <= state_next_s;
            lock_ch_r <= lock_ch_next_s;
        end
    end

    // Enter lock on a non-final beat, leave it on the locked channel's last beat.
    always_comb begin
        state_next_s   = state_r;
        lock_ch_next_s = lock_ch_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s && !sel_last_s) begin
                    state_next_s   = ST_LOCKED;
                    lock_ch_next_s = sel_chan_s;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_LOCKED: begin
                if (xfer_s && sel_last_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                lock_ch_next_s = '0;
            end
        endcase
    end

    // Lock controls for the arbiter; ptr moves only when a packet completes.
    always_comb begin
        lock_ch_s = lock_ch_r;
        ptr_adv_s = xfer_s && sel_last_s;
        case (state_r)
            ST_IDLE:   lock_s = 1'b0;
            ST_LOCKED: lock_s = 1'b1;
            default:   lock_s = 1'b0;
        endcase
    end
`else
    // Without packet lock every beat is re-arbitrated and always moves ptr.
    always_comb begin
        lock_s    = 1'b0;
        lock_ch_s = '0;
        ptr_adv_s = xfer_s;
    end
`endif

    // Round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (ptr_adv_s) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Output register: load on transfer, empty when drained with no request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_chan_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (load_en_s) begin
            if (xfer_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= sel_data_s;
                out_chan_r  <= sel_chan_s;
                out_last_r  <= sel_last_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_chan  = out_chan_r;
    assign bus.out_last  = out_last_r;

endmodule
